axis_lane_packer: RTL and testbench

Parametrised AXI-Stream lane packer. It accepts input beats with sparse or partial `tkeep` masks and removes the gaps. The valid lanes are packed in arrival order into dense, full-width output beats. A partial final beat is flushed on `tlast`. It sits between sub-word producers (nibble/byte sources) and full-word consumers, and generalises our fixed 16-bit nibble accumulator to any lane width and lane count with arbitrary keep masks.

---
 rtl/axis_lane_packer.sv | 180 ++++++++++++++++++
 tb/tb_axis_lane_packer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_lane_packer.sv
// AXI-Stream lane packer: compacts sparse tkeep lanes into dense full-width beats, flushing partial beats on tlast.
// Optional statistics counters are enabled by defining PACKER_STATS_EN.
`timescale 1ns/1ps
module axis_lane_packer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4,
    localparam int DATA_W = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [LANES-1:0]  s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [LANES-1:0]  m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]       stat_beats_in,
    output logic [31:0]       stat_pkts_out
`endif
);

    localparam int OCC_W = $clog2(2 * LANES + 1);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [OCC_W-1:0] LANES_OCC = OCC_W'(LANES);
    localparam logic [OCC_W-1:0] ZERO_OCC  = {OCC_W{1'b0}};

    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] keep);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            cnt = cnt + CNT_W'(keep[i]);
        end
        return cnt;
    endfunction

    function automatic logic [DATA_W-1:0] compact(input logic [DATA_W-1:0] data,
                                                  input logic [LANES-1:0]  keep);
        logic [DATA_W-1:0] res;
        int                idx;
        res = {DATA_W{1'b0}};
        idx = 0;
        for (int i = 0; i < LANES; i++) begin
            if (keep[i]) begin
                res[idx*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
                idx = idx + 1;
            end else begin
                idx = idx;
            end
        end
        return res;
    endfunction

    logic [2*DATA_W-1:0] acc_r;
    logic [2*DATA_W-1:0] acc_shift_s;
    logic [2*DATA_W-1:0] wr_s;
    logic [2*DATA_W-1:0] acc_nxt_s;
    logic [OCC_W-1:0]    occ_r;
    logic [OCC_W-1:0]    pop_lanes_s;
    logic [OCC_W-1:0]    occ_pop_s;
    logic [OCC_W-1:0]    occ_nxt_s;
    logic                last_pend_r;
    logic                empty_last_r;
    logic                full_s;
    logic                flush_s;
    logic                valid_s;
    logic                tlast_s;
    logic                pop_s;
    logic                push_s;
    logic                ready_s;
    logic [CNT_W-1:0]    n_s;
    logic [DATA_W-1:0]   comp_s;
    logic [LANES-1:0]    keep_s;
    logic [LANES-1:0]    occ_mask_s;

    // Output beat classification, keep mask and tlast from the current occupancy.
    always_comb begin
        full_s  = (occ_r >= LANES_OCC);
        flush_s = last_pend_r && (occ_r != ZERO_OCC) && (occ_r < LANES_OCC);
        valid_s = full_s || (last_pend_r && (occ_r != ZERO_OCC)) || empty_last_r;
        for (int i = 0; i < LANES; i++) begin
            occ_mask_s[i] = (OCC_W'(i) < occ_r);
        end
        if (full_s) begin
            keep_s  = {LANES{1'b1}};
            tlast_s = last_pend_r && (occ_r == LANES_OCC);
        end else if (flush_s) begin
            keep_s  = occ_mask_s;
            tlast_s = 1'b1;
        end else begin
            keep_s  = {LANES{1'b0}};
            tlast_s = empty_last_r;
        end
    end

    // Handshakes, post-pop occupancy and next accumulator contents.
    always_comb begin
        pop_s = valid_s && m_axis_tready;
        if (pop_s) begin
            pop_lanes_s = full_s ? LANES_OCC : occ_r;
        end else begin
            pop_lanes_s = ZERO_OCC;
        end
        occ_pop_s = occ_r - pop_lanes_s;
        ready_s   = !areset && !last_pend_r && !empty_last_r && (occ_pop_s <= LANES_OCC);
        push_s    = s_axis_tvalid && ready_s;
        n_s       = popcount(s_axis_tkeep);
        comp_s    = compact(s_axis_tdata, s_axis_tkeep);
        // Lanes at or above occ are always zero, so any pop may shift a full beat out.
        acc_shift_s = pop_s ? (acc_r >> DATA_W) : acc_r;
        if (push_s) begin
            wr_s      = {{DATA_W{1'b0}}, comp_s} << (int'(occ_pop_s) * LANE_W);
            occ_nxt_s = occ_pop_s + OCC_W'(n_s);
        end else begin
            wr_s      = {(2*DATA_W){1'b0}};
            occ_nxt_s = occ_pop_s;
        end
        acc_nxt_s = acc_shift_s | wr_s;
    end

    // Accumulator, occupancy and packet-boundary flags.
    always_ff @(posedge clk) begin
        if (areset) begin
            acc_r        <= {(2*DATA_W){1'b0}};
            occ_r        <= ZERO_OCC;
            last_pend_r  <= 1'b0;
            empty_last_r <= 1'b0;
        end else begin
            acc_r <= acc_nxt_s;
            occ_r <= occ_nxt_s;
            if (push_s && s_axis_tlast && (occ_nxt_s != ZERO_OCC)) begin
                last_pend_r <= 1'b1;
            end else if (pop_s && tlast_s) begin
                last_pend_r <= 1'b0;
            end
            if (push_s && s_axis_tlast && (occ_nxt_s == ZERO_OCC)) begin
                empty_last_r <= 1'b1;
            end else if (pop_s && empty_last_r) begin
                empty_last_r <= 1'b0;
            end
        end
    end

    assign s_axis_tready = ready_s;
    assign m_axis_tdata  = acc_r[DATA_W-1:0];
    assign m_axis_tkeep  = keep_s;
    assign m_axis_tlast  = tlast_s;
    assign m_axis_tvalid = valid_s;

`ifdef PACKER_STATS_EN
    logic [31:0] stat_beats_r;
    logic [31:0] stat_pkts_r;

    // Saturating counters of accepted input beats and emitted packets.
    always_ff @(posedge clk) begin
        if (areset) begin
            stat_beats_r <= 32'd0;
            stat_pkts_r  <= 32'd0;
        end else begin
            if (push_s && (stat_beats_r != 32'hFFFF_FFFF)) begin
                stat_beats_r <= stat_beats_r + 32'd1;
            end
            if (pop_s && tlast_s && (stat_pkts_r != 32'hFFFF_FFFF)) begin
                stat_pkts_r <= stat_pkts_r + 32'd1;
            end
        end
    end

    assign stat_beats_in = stat_beats_r;
    assign stat_pkts_out = stat_pkts_r;
`else
    // Statistics hardware is not built in this configuration.
`endif

endmodule

// File: tb/tb_axis_lane_packer.sv
// Self-checking bench for axis_lane_packer (LANES=4, LANE_W=4): directed vector table plus randomized traffic vs a lane-queue model.
`timescale 1ns/1ps
module tb_axis_lane_packer;

    localparam int LANES  = 4;
    localparam int LANE_W = 4;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              areset;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [LANES-1:0]  s_axis_tkeep;
    logic              s_axis_tlast;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [LANES-1:0]  m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
`ifdef PACKER_STATS_EN
    logic [31:0]       stat_beats_in;
    logic [31:0]       stat_pkts_out;
`endif

    always #5 clk = ~clk;

    axis_lane_packer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk           (clk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef PACKER_STATS_EN
        ,
        .stat_beats_in (stat_beats_in),
        .stat_pkts_out (stat_pkts_out)
`endif
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of lanes not yet delivered, plus packet-end markers.
    logic [3:0]  mq[$];
    bit          m_end;
    bit          m_empty;
    int unsigned exp_beats_in;
    int unsigned exp_pkts_out;

    task automatic model_clear();
        mq.delete();
        m_end        = 1'b0;
        m_empty      = 1'b0;
        exp_beats_in = 0;
        exp_pkts_out = 0;
    endtask

    task automatic model_check();
        int sz, k, pl;
        bit v, r, l;
        logic [15:0] d;
        logic [3:0]  kp;
        sz = mq.size();
        k  = (sz < 4) ? sz : 4;
        v  = (sz >= 4) || (m_end && sz > 0) || m_empty;
        d  = 16'h0;
        for (int i = 0; i < k; i++) d[i*4 +: 4] = mq[i];
        kp = (sz >= 4) ? 4'hF : 4'((1 << k) - 1);
        l  = m_empty || (m_end && sz <= 4);
        pl = (v && m_axis_tready) ? k : 0;
        r  = !m_end && !m_empty && ((sz - pl) <= 4);
        chk("mdl_valid", {31'd0, m_axis_tvalid}, {31'd0, v});
        chk("mdl_ready", {31'd0, s_axis_tready}, {31'd0, r});
        if (v) begin
            chk("mdl_tdata", {16'd0, m_axis_tdata}, {16'd0, d});
            chk("mdl_tkeep", {28'd0, m_axis_tkeep}, {28'd0, kp});
            chk("mdl_tlast", {31'd0, m_axis_tlast}, {31'd0, l});
        end
    endtask

    task automatic model_update(input bit push, input bit pop, input logic [3:0] keep,
                                input logic [15:0] data, input logic last);
        int k;
        bit tl;
        if (pop) begin
            if (m_empty) begin
                m_empty = 1'b0;
                exp_pkts_out++;
            end else begin
                k  = (mq.size() < 4) ? mq.size() : 4;
                tl = m_end && (mq.size() <= 4);
                for (int i = 0; i < k; i++) void'(mq.pop_front());
                if (tl) begin
                    m_end = 1'b0;
                    exp_pkts_out++;
                end
            end
        end
        if (push) begin
            exp_beats_in++;
            for (int i = 0; i < 4; i++) if (keep[i]) mq.push_back(data[i*4 +: 4]);
            if (last) begin
                if (mq.size() == 0) m_empty = 1'b1;
                else                m_end   = 1'b1;
            end
        end
    endtask

    task automatic apply(input logic sv, input logic [3:0] keep, input logic [15:0] data,
                         input logic last, input logic mr);
        s_axis_tvalid = sv;
        s_axis_tkeep  = keep;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        m_axis_tready = mr;
        #1;
        if (!areset) model_check();
    endtask

    task automatic advance();
        bit rst, pu, po;
        logic [3:0]  kp;
        logic [15:0] d;
        logic        l;
        rst = areset;
        pu  = s_axis_tvalid && s_axis_tready;
        po  = m_axis_tvalid && m_axis_tready;
        kp  = s_axis_tkeep;
        d   = s_axis_tdata;
        l   = s_axis_tlast;
        @(posedge clk);
        if (rst) model_clear();
        else     model_update(pu, po, kp, d, l);
        @(negedge clk);
    endtask

    typedef struct {
        logic        sv;
        logic [3:0]  keep;
        logic [15:0] data;
        logic        last;
        logic        mr;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic        er;
    } vec_t;

    vec_t tbl [27];

    initial begin
        // Directed cycle table: inputs this cycle, expected outputs in the same cycle.
        tbl[0]  = '{1'b1, 4'h3, 16'h0021, 1'b0, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 4'h3, 16'h0043, 1'b0, 1'b1,  1'b0, 16'h0021, 4'h0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 4'h3, 16'h0065, 1'b0, 1'b1,  1'b1, 16'h4321, 4'hF, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 4'h3, 16'h0087, 1'b0, 1'b1,  1'b0, 16'h0065, 4'h0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h8765, 4'hF, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 4'hA, 16'hB0A0, 1'b0, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 4'h5, 16'h0D0C, 1'b0, 1'b1,  1'b0, 16'h00BA, 4'h0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'hDCBA, 4'hF, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 4'h7, 16'h0321, 1'b1, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 4'hF, 16'hFFFF, 1'b0, 1'b0,  1'b1, 16'h0321, 4'h7, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'hF, 16'hFFFF, 1'b0, 1'b1,  1'b1, 16'h0321, 4'h7, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 4'h0, 16'h1234, 1'b1, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0,  1'b1, 16'h0000, 4'h0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h0000, 4'h0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 4'h0, 16'h5555, 1'b0, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 4'hF, 16'h1111, 1'b0, 1'b0,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 4'hF, 16'h2222, 1'b0, 1'b0,  1'b1, 16'h1111, 4'hF, 1'b0, 1'b1};
        tbl[20] = '{1'b1, 4'hF, 16'h3333, 1'b0, 1'b0,  1'b1, 16'h1111, 4'hF, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 4'hF, 16'h3333, 1'b0, 1'b0,  1'b1, 16'h1111, 4'hF, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 4'hF, 16'h3333, 1'b0, 1'b0,  1'b1, 16'h1111, 4'hF, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 4'hF, 16'h3333, 1'b0, 1'b1,  1'b1, 16'h1111, 4'hF, 1'b0, 1'b1};
        tbl[24] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h2222, 4'hF, 1'b0, 1'b1};
        tbl[25] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h3333, 4'hF, 1'b0, 1'b1};
        tbl[26] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b1};

        model_clear();

        // Reset held for three cycles with random input activity.
        areset        = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tkeep  = 4'($urandom);
        s_axis_tdata  = 16'($urandom);
        s_axis_tlast  = 1'($urandom);
        m_axis_tready = 1'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
            chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
            chk("rst_tdata",  {16'd0, m_axis_tdata},  32'd0);
            chk("rst_tkeep",  {28'd0, m_axis_tkeep},  32'd0);
            chk("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
`ifdef PACKER_STATS_EN
            chk("rst_stat_beats", stat_beats_in, 32'd0);
            chk("rst_stat_pkts",  stat_pkts_out, 32'd0);
`endif
            @(negedge clk);
            s_axis_tkeep  = 4'($urandom);
            s_axis_tdata  = 16'($urandom);
            s_axis_tlast  = 1'($urandom);
            m_axis_tready = 1'($urandom);
        end
        areset = 1'b0;
        model_clear();

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i].sv, tbl[i].keep, tbl[i].data, tbl[i].last, tbl[i].mr);
            chk($sformatf("vec%0d_tvalid", i), {31'd0, m_axis_tvalid}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d_tready", i), {31'd0, s_axis_tready}, {31'd0, tbl[i].er});
            chk($sformatf("vec%0d_tdata", i),  {16'd0, m_axis_tdata},  {16'd0, tbl[i].ed});
            chk($sformatf("vec%0d_tkeep", i),  {28'd0, m_axis_tkeep},  {28'd0, tbl[i].ek});
            chk($sformatf("vec%0d_tlast", i),  {31'd0, m_axis_tlast},  {31'd0, tbl[i].el});
            advance();
        end
`ifdef PACKER_STATS_EN
        chk("stat_beats_dir", stat_beats_in, exp_beats_in);
        chk("stat_pkts_dir",  stat_pkts_out, exp_pkts_out);
`endif

        // Randomized traffic with a mid-packet reset partway through.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] kp;
            kp = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            if (i == 1500) begin
                areset = 1'b1;
                apply(1'b1, kp, 16'($urandom), 1'b0, 1'b1);
                advance();
                areset = 1'b0;
                apply(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
                chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
                chk("midrst_tready", {31'd0, s_axis_tready}, 32'd1);
                advance();
            end else begin
                apply($urandom_range(0, 3) != 0, kp, 16'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
                advance();
            end
        end

        for (int i = 0; i < 30; i++) begin
            apply(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
            advance();
        end
        apply(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
        chk("drain_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("drain_tready", {31'd0, s_axis_tready}, 32'd1);
`ifdef PACKER_STATS_EN
        chk("stat_beats_rand", stat_beats_in, exp_beats_in);
        chk("stat_pkts_rand",  stat_pkts_out, exp_pkts_out);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
